// File: rtl/local_mem_responder.sv
// -----------------------------------------------------------------------------
// local_mem_responder
//
// Memory-side endpoint for the core's shared memory master port. Tagged
// requests (read, burst read, byte-enabled write, read-modify-write) enter an
// in-order queue. They are serviced one at a time from an internal
// word-addressed RAM.
//
// Handshake: request/ack is a valid/accept pair. A request is taken in exactly
// the cycles where request=1 and ack=1, and ack is request & !full. A pop in the
// same cycle does not make room; the slot frees up in the next cycle. The
// rvalid/rdata/rid beat stream has no ready: the consumer must take every beat.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   request            request valid
//   addr[29:0]         word address (byte address bits [31:2])
//   rlen[4:0]          read burst length minus one (reads only)
//   rnw, rmw           1/x = read, 0/0 = write, 0/1 = read-modify-write
//   id[1:0]            requester tag, returned on rid with each read beat
//   wbe[3:0], wdata    write byte enables / data
//   ack                request accepted this cycle
//   rvalid, rdata, rid registered read beat, data and tag
//   inv, inv_addr      one-cycle pulse in the cycle after each RAM write
//   write_outstanding  a write or rmw is queued or has not yet committed
//   dbg_state          action the FSM is performing this cycle (state_t code)
// -----------------------------------------------------------------------------
module local_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [29:0] addr,
  input  logic [4:0]  rlen,
  input  logic        rnw,
  input  logic        rmw,
  input  logic [1:0]  id,
  input  logic [3:0]  wbe,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rid,
  output logic        inv,
  output logic [29:0] inv_addr,
  output logic        write_outstanding,
  output logic [2:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int QW = $clog2(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WRITE  = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [4:0]  rlen;
    logic        rnw;
    logic        rmw;
    logic [1:0]  id;
    logic [3:0]  wbe;
    logic [31:0] wdata;
  } req_t;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] mem   [DEPTH_WORDS];
  req_t        q_mem [QUEUE_DEPTH];

  // ---------------------------------------------------------------------------
  // Queue bookkeeping
  // ---------------------------------------------------------------------------
  logic [QW-1:0] head_q, tail_q;
  logic [QW:0]   count_q, count_d;
  logic [QW:0]   wr_cnt_q, wr_cnt_d;   // writes/rmws currently in the queue
  logic          full, empty, push, pop;
  req_t          req_in, head;

  assign full   = (count_q == (QW+1)'(QUEUE_DEPTH));
  assign empty  = (count_q == '0);
  assign ack    = request & ~full & ~rst;
  assign push   = ack;
  assign head   = q_mem[head_q];

  assign req_in = '{addr: addr, rlen: rlen, rnw: rnw, rmw: rmw,
                    id: id, wbe: wbe, wdata: wdata};

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    case ({push & ~rnw, pop & ~head.rnw})
      2'b10:   wr_cnt_d = wr_cnt_q + 1'b1;
      2'b01:   wr_cnt_d = wr_cnt_q - 1'b1;
      default: wr_cnt_d = wr_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[tail_q] <= req_in;
  end

  // ---------------------------------------------------------------------------
  // Service FSM
  // The first action of every request (read issue, write commit, rmw read)
  // happens in the IDLE cycle that pops it, so the registered state only ever
  // holds IDLE, READ (remaining burst beats) and RMW_WR. dbg_state reports the
  // action being taken, which includes WRITE and RMW_RD on pop cycles.
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [4:0]  beat_q, beat_d;
  logic [29:0] ctx_addr_q;
  logic [4:0]  ctx_rlen_q;
  logic [1:0]  ctx_id_q;
  logic [3:0]  ctx_wbe_q;
  logic [31:0] ctx_wdata_q;

  logic          mem_re;
  logic [AW-1:0] mem_ridx;
  logic [1:0]    rid_d;
  logic          mem_we;
  logic [29:0]   mem_waddr;
  logic [3:0]    mem_wbe;
  logic [31:0]   mem_wdat;
  state_t        act_state;

  assign pop = (state_q == IDLE) & ~empty;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    mem_re    = 1'b0;
    mem_ridx  = '0;
    rid_d     = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wbe   = '0;
    mem_wdat  = '0;
    act_state = state_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (head.rnw) begin
            act_state = READ;
            mem_re    = 1'b1;
            mem_ridx  = head.addr[AW-1:0];
            rid_d     = head.id;
            beat_d    = 5'd1;
            if (head.rlen != 5'd0) state_d = READ;
          end else if (head.rmw) begin
            act_state = RMW_RD;
            mem_re    = 1'b1;
            mem_ridx  = head.addr[AW-1:0];
            rid_d     = head.id;
            state_d   = RMW_WR;
          end else begin
            act_state = WRITE;
            mem_we    = 1'b1;
            mem_waddr = head.addr;
            mem_wbe   = head.wbe;
            mem_wdat  = head.wdata;
          end
        end
      end
      READ: begin
        // Burst index wraps modulo the RAM size.
        mem_re   = 1'b1;
        mem_ridx = ctx_addr_q[AW-1:0] + AW'(beat_q);
        rid_d    = ctx_id_q;
        if (beat_q == ctx_rlen_q) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 5'd1;
        end
      end
      RMW_WR: begin
        // rdata still holds the old word read in the previous cycle.
        mem_we    = 1'b1;
        mem_waddr = ctx_addr_q;
        mem_wbe   = 4'hF;
        mem_wdat  = merge_bytes(rdata, ctx_wdata_q, ctx_wbe_q);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dbg_state         = act_state;
  assign write_outstanding = (wr_cnt_q != '0) | (state_q == RMW_WR);

  // RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wbe[b]) mem[mem_waddr[AW-1:0]][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wr_cnt_q    <= '0;
      ctx_addr_q  <= '0;
      ctx_rlen_q  <= '0;
      ctx_id_q    <= '0;
      ctx_wbe_q   <= '0;
      ctx_wdata_q <= '0;
      rvalid      <= 1'b0;
      rdata       <= '0;
      rid         <= '0;
      inv         <= 1'b0;
      inv_addr    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      count_q  <= count_d;
      wr_cnt_q <= wr_cnt_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop) begin
        head_q      <= head_q + 1'b1;
        ctx_addr_q  <= head.addr;
        ctx_rlen_q  <= head.rlen;
        ctx_id_q    <= head.id;
        ctx_wbe_q   <= head.wbe;
        ctx_wdata_q <= head.wdata;
      end
      rvalid <= mem_re;
      if (mem_re) begin
        rdata <= mem[mem_ridx];
        rid   <= rid_d;
      end
      inv <= mem_we;
      if (mem_we) inv_addr <= mem_waddr;
    end
  end

endmodule

// File: tb/tb_local_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_local_mem_responder
//
// Directed bench for local_mem_responder (DEPTH_WORDS=1024, QUEUE_DEPTH=4).
// Inputs change 1 time unit after the rising edge, and outputs are sampled there.
// Every expected value is a hand-computed constant.
// -----------------------------------------------------------------------------
module tb_local_mem_responder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        request = 1'b0;
  logic [29:0] addr    = '0;
  logic [4:0]  rlen    = '0;
  logic        rnw     = 1'b0;
  logic        rmw     = 1'b0;
  logic [1:0]  id      = '0;
  logic [3:0]  wbe     = '0;
  logic [31:0] wdata   = '0;
  logic        ack;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rid;
  logic        inv;
  logic [29:0] inv_addr;
  logic        write_outstanding;
  logic [2:0]  dbg_state;

  local_mem_responder #(
    .DEPTH_WORDS(1024),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .request           (request),
    .addr              (addr),
    .rlen              (rlen),
    .rnw               (rnw),
    .rmw               (rmw),
    .id                (id),
    .wbe               (wbe),
    .wdata             (wdata),
    .ack               (ack),
    .rvalid            (rvalid),
    .rdata             (rdata),
    .rid               (rid),
    .inv               (inv),
    .inv_addr          (inv_addr),
    .write_outstanding (write_outstanding),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];   // {rid, rdata} of queued single reads

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in an empty-queue situation, expects ack, and returns
  // one cycle later with request dropped.
  task automatic send(input logic [29:0] a, input logic [4:0] l, input logic r,
                      input logic m, input logic [1:0] i, input logic [3:0] be,
                      input logic [31:0] d);
    request = 1'b1;
    addr    = a;
    rlen    = l;
    rnw     = r;
    rmw     = m;
    id      = i;
    wbe     = be;
    wdata   = d;
    #1;
    chk("ack", 32'(ack), 32'h1);
    step();
    request = 1'b0;
  endtask

  // Single-beat read: beat expected two cycles after the request cycle.
  task automatic read_check(input string tag, input logic [29:0] a,
                            input logic [1:0] i, input logic [31:0] exp);
    send(a, 5'd0, 1'b1, 1'b0, i, 4'h0, 32'h0);
    chk({tag, "_early"}, 32'(rvalid), 32'h0);
    step();
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h1);
    chk({tag, "_rdata"}, rdata, exp);
    chk({tag, "_rid"}, 32'(rid), 32'(i));
    step();
    chk({tag, "_rvalid_end"}, 32'(rvalid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] wrap_exp [4];
    logic [33:0] ent      [4];
    logic [29:0] ent_addr [4];
    int n;
    logic [33:0] e;

    wrap_exp = '{32'hB00003FE, 32'hB00003FF, 32'hB0000000, 32'hB0000001};
    ent      = '{{2'd1, 32'hDEADBEEF}, {2'd2, 32'h11BB33DD},
                 {2'd3, 32'h00000009}, {2'd0, 32'hB00003FF}};
    ent_addr = '{30'h10, 30'h20, 30'h8, 30'h3FF};

    // Reset state
    repeat (3) step();
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rid", 32'(rid), 32'h0);
    chk("rst_inv", 32'(inv), 32'h0);
    chk("rst_inv_addr", 32'(inv_addr), 32'h0);
    chk("rst_wo", 32'(write_outstanding), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    rst = 1'b0;
    step();

    // Preload through the port with full-word writes
    send(30'h010, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hDEADBEEF);
    send(30'h3FE, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hB00003FE);
    send(30'h3FF, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hB00003FF);
    send(30'h000, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hB0000000);
    send(30'h001, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'hB0000001);
    send(30'h020, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h11223344);
    send(30'h008, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h00000005);
    repeat (3) step();
    chk("pre_inv_idle", 32'(inv), 32'h0);
    chk("pre_wo_idle", 32'(write_outstanding), 32'h0);

    // Single read
    read_check("single", 30'h010, 2'd2, 32'hDEADBEEF);

    // Burst wrapping past the top of the RAM
    send(30'h3FE, 5'd3, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
    for (int b = 0; b < 4; b++) begin
      step();
      chk("wrap_rvalid", 32'(rvalid), 32'h1);
      chk("wrap_rdata", rdata, wrap_exp[b]);
      chk("wrap_rid", 32'(rid), 32'h1);
    end
    step();
    chk("wrap_end", 32'(rvalid), 32'h0);

    // Byte-enabled write, then read back
    send(30'h020, 5'd0, 1'b0, 1'b0, 2'd0, 4'b0101, 32'hAABBCCDD);
    chk("bw_wo_commit", 32'(write_outstanding), 32'h1);
    chk("bw_inv_commit", 32'(inv), 32'h0);
    chk("bw_dbg_write", 32'(dbg_state), 32'h2);
    step();
    chk("bw_inv", 32'(inv), 32'h1);
    chk("bw_inv_addr", 32'(inv_addr), 32'h20);
    chk("bw_wo_clear", 32'(write_outstanding), 32'h0);
    step();
    chk("bw_inv_end", 32'(inv), 32'h0);
    read_check("bw_read", 30'h020, 2'd0, 32'h11BB33DD);

    // Read-modify-write
    send(30'h008, 5'd0, 1'b0, 1'b1, 2'd3, 4'hF, 32'h00000009);
    chk("rmw_wo_rd", 32'(write_outstanding), 32'h1);
    chk("rmw_dbg_rd", 32'(dbg_state), 32'h3);
    chk("rmw_rvalid_early", 32'(rvalid), 32'h0);
    step();
    chk("rmw_rvalid", 32'(rvalid), 32'h1);
    chk("rmw_old", rdata, 32'h00000005);
    chk("rmw_rid", 32'(rid), 32'h3);
    chk("rmw_wo_wr", 32'(write_outstanding), 32'h1);
    chk("rmw_inv_wr", 32'(inv), 32'h0);
    chk("rmw_dbg_wr", 32'(dbg_state), 32'h4);
    step();
    chk("rmw_inv", 32'(inv), 32'h1);
    chk("rmw_inv_addr", 32'(inv_addr), 32'h8);
    chk("rmw_wo_clear", 32'(write_outstanding), 32'h0);
    chk("rmw_rvalid_end", 32'(rvalid), 32'h0);
    step();
    read_check("rmw_read", 30'h008, 2'd1, 32'h00000009);

    // Write immediately followed by a read of the same word
    send(30'h030, 5'd0, 1'b0, 1'b0, 2'd0, 4'hF, 32'h12345678);
    send(30'h030, 5'd0, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
    chk("raw_early", 32'(rvalid), 32'h0);
    step();
    chk("raw_rvalid", 32'(rvalid), 32'h1);
    chk("raw_rdata", rdata, 32'h12345678);
    chk("raw_rid", 32'(rid), 32'h1);
    step();

    // Back-to-back reads: no gap between bursts
    send(30'h3FE, 5'd1, 1'b1, 1'b0, 2'd2, 4'h0, 32'h0);
    send(30'h010, 5'd0, 1'b1, 1'b0, 2'd3, 4'h0, 32'h0);
    chk("b2b_v0", 32'(rvalid), 32'h1);
    chk("b2b_d0", rdata, 32'hB00003FE);
    chk("b2b_id0", 32'(rid), 32'h2);
    step();
    chk("b2b_v1", 32'(rvalid), 32'h1);
    chk("b2b_d1", rdata, 32'hB00003FF);
    step();
    chk("b2b_v2", 32'(rvalid), 32'h1);
    chk("b2b_d2", rdata, 32'hDEADBEEF);
    chk("b2b_id2", 32'(rid), 32'h3);
    step();
    chk("b2b_end", 32'(rvalid), 32'h0);
    step();

    // Backpressure: a 32-beat read occupies the FSM while request is held
    // for 6 cycles; 4 entries fit, the last 2 cycles see a full queue.
    send(30'h000, 5'd31, 1'b1, 1'b0, 2'd0, 4'h0, 32'h0);
    n = 0;
    for (int c = 1; c <= 38; c++) begin
      if (c <= 6) begin
        request = 1'b1;
        addr    = ent_addr[n];
        rlen    = 5'd0;
        rnw     = 1'b1;
        rmw     = 1'b0;
        id      = ent[n][33:32];
        #1;
        chk("bp_ack", 32'(ack), (c <= 4) ? 32'h1 : 32'h0);
        if (c <= 4) begin
          exp_q.push_back(ent[n]);
          if (n < 3) n++;
        end
      end else begin
        request = 1'b0;
        #1;
      end
      chk("bp_rvalid", 32'(rvalid), (c >= 2 && c <= 37) ? 32'h1 : 32'h0);
      if (c >= 2 && c <= 33) begin
        chk("bp_long_rid", 32'(rid), 32'h0);
        if (c == 2)  chk("bp_long_b0", rdata, 32'hB0000000);
        if (c == 3)  chk("bp_long_b1", rdata, 32'hB0000001);
        if (c == 10) chk("bp_long_b8", rdata, 32'h00000009);
      end
      if (c >= 34 && c <= 37) begin
        e = exp_q.pop_front();
        chk("bp_q_rdata", rdata, e[31:0]);
        chk("bp_q_rid", 32'(rid), 32'(e[33:32]));
      end
      step();
    end
    chk("bp_q_drained", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of a burst
    send(30'h000, 5'd7, 1'b1, 1'b0, 2'd1, 4'h0, 32'h0);
    repeat (4) step();
    chk("mid_beat3", 32'(rvalid), 32'h1);
    rst     = 1'b1;
    request = 1'b1;
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rdata", rdata, 32'h0);
    chk("mid_rid", 32'(rid), 32'h0);
    chk("mid_inv_addr", 32'(inv_addr), 32'h0);
    chk("mid_wo", 32'(write_outstanding), 32'h0);
    chk("mid_ack", 32'(ack), 32'h0);
    request = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("post_rst_quiet", 32'(rvalid), 32'h0);
    end
    read_check("post_rst_read", 30'h010, 2'd2, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
